square_motion_controller: RTL

- Per-frame scheduler that drives the square-overlay configuration inputs of the VGA controller: square X offset, square Y offset and square colour.
- Synchronises and debounces five raw push-buttons, snapshots them once per frame during vertical blanking, and applies saturating position steps and colour cycling in a fixed three-cycle sequence.
- Outputs change only on the update line, so the square never tears inside the visible 256x256 window (V 141..396).

---
 rtl/square_motion_controller.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/square_motion_controller.sv
// rtl/square_motion_controller.sv - per-frame square position/colour scheduler for the VGA overlay
//
// Optional feature macro: SQUARE_AUTOBOUNCE_EN (released axes bounce between 0 and MAX_POS)
//
// Ports:
//   slow_clock                 pixel clock, shared with the VGA counters
//   Reset                      synchronous, active-high reset
//   iVcounter, iHcounter       VGA vertical/horizontal counters
//   iBtnUp/Down/Left/Right     raw asynchronous direction buttons
//   iBtnColor                  raw asynchronous colour-cycle button
//   oXRedCounter, oYRedCounter square offset, 0..MAX_POS
//   oColorCuadro               square RGB colour, never 3'b000
//   oFrameTick                 one-cycle pulse when a frame update starts
module square_motion_controller #(
    parameter int STEP            = 2,
    parameter int MAX_POS         = 224,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FRAME_LINE      = 400
) (
    input  logic       slow_clock,
    input  logic       Reset,
    input  logic [9:0] iVcounter,
    input  logic [9:0] iHcounter,
    input  logic       iBtnUp,
    input  logic       iBtnDown,
    input  logic       iBtnLeft,
    input  logic       iBtnRight,
    input  logic       iBtnColor,
    output logic [7:0] oXRedCounter,
    output logic [7:0] oYRedCounter,
    output logic [2:0] oColorCuadro,
    output logic       oFrameTick
);

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_COLOR = 4;

    localparam logic [7:0] POS_RESET     = 8'(MAX_POS / 2);
    localparam logic [7:0] MAX_POS8      = 8'(MAX_POS);
    localparam logic [8:0] MAX_POS9      = 9'(MAX_POS);
    localparam logic [8:0] STEP9         = 9'(STEP);
    localparam logic [7:0] DB_LAST       = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0] FRAME_LINE10  = 10'(FRAME_LINE);
    localparam logic [2:0] COLOR_RESET   = 3'b100;

    typedef enum logic [1:0] {
        WAIT_FRAME  = 2'd0,
        APPLY_X     = 2'd1,
        APPLY_Y     = 2'd2,
        APPLY_COLOR = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      btn_raw;
    logic [4:0]      sync1_q, sync1_d;
    logic [4:0]      sync2_q, sync2_d;
    logic [4:0]      db_q, db_d;
    logic [4:0][7:0] db_cnt_q, db_cnt_d;
    logic [3:0]      snap_q, snap_d;
    logic [7:0]      x_q, x_d;
    logic [7:0]      y_q, y_d;
    logic [2:0]      color_q, color_d;
    logic            pending_q, pending_d;
    logic            frame_tick_q, frame_tick_d;
    logic            tick;
    logic            color_rise;
`ifdef SQUARE_AUTOBOUNCE_EN
    logic            dir_x_q, dir_x_d;
    logic            dir_y_q, dir_y_d;
`endif

    // Saturating steps are done in 9 bits so pos+STEP cannot wrap before the clamp.
    function automatic logic [7:0] pos_inc(input logic [7:0] pos);
        logic [8:0] sum;
        sum = {1'b0, pos} + STEP9;
        pos_inc = (sum > MAX_POS9) ? MAX_POS8 : sum[7:0];
    endfunction

    function automatic logic [7:0] pos_dec(input logic [7:0] pos);
        logic [8:0] diff;
        diff = {1'b0, pos} - STEP9;
        pos_dec = ({1'b0, pos} < STEP9) ? 8'd0 : diff[7:0];
    endfunction

    assign btn_raw = {iBtnColor, iBtnRight, iBtnLeft, iBtnDown, iBtnUp};

    // Two-flop synchroniser followed by a per-button stability counter.
    // The counter only runs while the synchronised sample disagrees with the
    // accepted level; a single agreeing sample restarts it.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = 8'd0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = sync2_q[i];
                db_cnt_d[i] = 8'd0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 8'd1;
            end
        end
    end

    // Rising edge detected on the cycle the debounced level is accepted.
    assign color_rise = db_d[BTN_COLOR] & ~db_q[BTN_COLOR];

    assign tick = (iVcounter == FRAME_LINE10) && (iHcounter == 10'd0) && (state_q == WAIT_FRAME);

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        x_d          = x_q;
        y_d          = y_q;
        color_d      = color_q;
        frame_tick_d = tick;
        // A new press always sets the flag; the APPLY_COLOR clear below only
        // wins when no press arrives in the same cycle.
        pending_d    = pending_q | color_rise;
`ifdef SQUARE_AUTOBOUNCE_EN
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
`endif
        case (state_q)
            WAIT_FRAME: begin
                if (tick) begin
                    snap_d  = db_q[3:0];
                    state_d = APPLY_X;
                end
            end
            APPLY_X: begin
                if (snap_q[BTN_RIGHT] && !snap_q[BTN_LEFT]) begin
                    x_d = pos_inc(x_q);
                end else if (snap_q[BTN_LEFT] && !snap_q[BTN_RIGHT]) begin
                    x_d = pos_dec(x_q);
`ifdef SQUARE_AUTOBOUNCE_EN
                end else if (!snap_q[BTN_LEFT] && !snap_q[BTN_RIGHT]) begin
                    if (dir_x_q) begin
                        x_d = pos_inc(x_q);
                        if (pos_inc(x_q) == MAX_POS8) dir_x_d = 1'b0;
                    end else begin
                        x_d = pos_dec(x_q);
                        if (pos_dec(x_q) == 8'd0) dir_x_d = 1'b1;
                    end
`endif
                end
                state_d = APPLY_Y;
            end
            APPLY_Y: begin
                if (snap_q[BTN_DOWN] && !snap_q[BTN_UP]) begin
                    y_d = pos_inc(y_q);
                end else if (snap_q[BTN_UP] && !snap_q[BTN_DOWN]) begin
                    y_d = pos_dec(y_q);
`ifdef SQUARE_AUTOBOUNCE_EN
                end else if (!snap_q[BTN_UP] && !snap_q[BTN_DOWN]) begin
                    if (dir_y_q) begin
                        y_d = pos_inc(y_q);
                        if (pos_inc(y_q) == MAX_POS8) dir_y_d = 1'b0;
                    end else begin
                        y_d = pos_dec(y_q);
                        if (pos_dec(y_q) == 8'd0) dir_y_d = 1'b1;
                    end
`endif
                end
                state_d = APPLY_COLOR;
            end
            APPLY_COLOR: begin
                if (pending_q) begin
                    // Cycle 1..7 so the square is never black.
                    color_d   = (color_q == 3'd7) ? 3'd1 : color_q + 3'd1;
                    pending_d = color_rise;
                end
                state_d = WAIT_FRAME;
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (Reset) begin
            state_q      <= WAIT_FRAME;
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            db_cnt_q     <= '0;
            snap_q       <= '0;
            x_q          <= POS_RESET;
            y_q          <= POS_RESET;
            color_q      <= COLOR_RESET;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
`ifdef SQUARE_AUTOBOUNCE_EN
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            db_cnt_q     <= db_cnt_d;
            snap_q       <= snap_d;
            x_q          <= x_d;
            y_q          <= y_d;
            color_q      <= color_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
`ifdef SQUARE_AUTOBOUNCE_EN
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
`endif
        end
    end

    assign oXRedCounter = x_q;
    assign oYRedCounter = y_q;
    assign oColorCuadro = color_q;
    assign oFrameTick   = frame_tick_q;

endmodule
